corr_chip_tx: RTL and testbench

- Transmit-side counterpart of the correlator receive chain (digitizer + dispatcher).
- Accepts one byte per frame over a valid/ready handshake and emits a framed, direct-sequence-spread chip stream on a single output pin, such as pwm_out or an LVDS driver.
- Each bit is sent as the spreading code (bit=1) or the inverted code (bit=0); the receiver correlates against the same code.

---
 rtl/corr_pkg.sv | 19 +
 rtl/corr_chip_gen.sv | 55 +++++
 rtl/corr_chip_tx.sv | 95 +++++++++
 tb/tb_corr_chip_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Constants and state encoding shared by the correlator transmit and receive chains.
package corr_pkg;

    localparam int BARKER_LEN = 13;
    localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1111100110101;

    localparam int SYNC_LEN = 4;
    localparam logic [SYNC_LEN-1:0] SYNC_PREAMBLE = 4'b1110;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/corr_chip_gen.sv
// Chip timing and spreading: divides clk into chips, walks the code and
// registers the spread chip, flagging chip and bit boundaries.
module corr_chip_gen
    import corr_pkg::*;
#(
    parameter int CODE_LEN = BARKER_LEN,
    parameter logic [CODE_LEN-1:0] CODE = BARKER13,
    parameter int CHIP_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic cur_bit,
    input  logic force_zero,
    output logic chip_out,
    output logic chip_end,
    output logic bit_end,
    output logic bit_start
);

    localparam int DW = $clog2(CHIP_DIV);
    localparam int CW = $clog2(CODE_LEN);

    logic [DW-1:0] div_ctr;
    logic [CW-1:0] chip_idx;
    logic [CODE_LEN-1:0] code_rev;

    // Reverse once so chip_idx indexes the code in transmit order.
    for (genvar i = 0; i < CODE_LEN; i++) begin : g_rev
        assign code_rev[i] = CODE[CODE_LEN-1-i];
    end

    assign chip_end  = enable && (div_ctr == DW'(CHIP_DIV - 1));
    assign bit_end   = chip_end && (chip_idx == CW'(CODE_LEN - 1));
    assign bit_start = enable && (div_ctr == '0) && (chip_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_ctr  <= '0;
            chip_idx <= '0;
            chip_out <= 1'b0;
        end else if (!enable) begin
            div_ctr  <= '0;
            chip_idx <= '0;
            chip_out <= 1'b0;
        end else begin
            div_ctr <= chip_end ? '0 : div_ctr + DW'(1);
            if (chip_end) begin
                chip_idx <= bit_end ? '0 : chip_idx + CW'(1);
            end
            chip_out <= force_zero ? 1'b0 : (code_rev[chip_idx] ~^ cur_bit);
        end
    end

endmodule

// File: rtl/corr_chip_tx.sv
// Byte-in, DSSS chip-out framer: preamble, LSB-first data, then a zero guard gap.
module corr_chip_tx
    import corr_pkg::*;
#(
    parameter int CODE_LEN = BARKER_LEN,
    parameter logic [CODE_LEN-1:0] CODE = BARKER13,
    parameter int CHIP_DIV = 16,
    parameter int PRE_LEN = SYNC_LEN,
    parameter logic [PRE_LEN-1:0] PREAMBLE = SYNC_PREAMBLE,
    parameter int GAP_CHIPS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       chip_out,
    output logic       busy,
    output logic       bit_strobe
);

    tx_state_t state, next_state;

    logic [7:0] shreg;
    logic [PRE_LEN-1:0] pre_sr;
    logic [7:0] bit_idx;
    logic take, cur_bit, chip_end, bit_end, bit_start;

    assign take    = data_valid && data_ready;
    assign cur_bit = (state == ST_PRE) ? pre_sr[PRE_LEN-1] : shreg[0];

    corr_chip_gen #(
        .CODE_LEN (CODE_LEN),
        .CODE     (CODE),
        .CHIP_DIV (CHIP_DIV)
    ) u_gen (
        .clk        (clk),
        .rst        (rst),
        .enable     (state != ST_IDLE),
        .cur_bit    (cur_bit),
        .force_zero (state == ST_GAP),
        .chip_out   (chip_out),
        .chip_end   (chip_end),
        .bit_end    (bit_end),
        .bit_start  (bit_start)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In GAP, bit_idx counts guard chips instead of bits.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (take) next_state = ST_PRE;
            ST_PRE:  if (bit_end && bit_idx == 8'(PRE_LEN - 1)) next_state = ST_DATA;
            ST_DATA: if (bit_end && bit_idx == 8'(DATA_BITS - 1)) next_state = ST_GAP;
            ST_GAP:  if (chip_end && bit_idx == 8'(GAP_CHIPS - 1)) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_idx    <= '0;
            shreg      <= '0;
            pre_sr     <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            data_ready <= (next_state == ST_IDLE);
            busy       <= (next_state != ST_IDLE);
            bit_strobe <= bit_start && (state == ST_PRE || state == ST_DATA);
            if (next_state != state) begin
                bit_idx <= '0;
            end else if ((state == ST_GAP) ? chip_end : bit_end) begin
                bit_idx <= bit_idx + 8'd1;
            end
            if (take) begin
                shreg  <= data_in;
                pre_sr <= PREAMBLE;
            end else if (bit_end) begin
                if (state == ST_DATA) shreg <= shreg >> 1;
                if (state == ST_PRE) pre_sr <= pre_sr << 1;
            end
        end
    end

endmodule

// File: tb/tb_corr_chip_tx.sv
// Bench for corr_chip_tx: fast (CHIP_DIV=2) and default instances checked
// cycle by cycle against a frame model built from the chip/bit rules.
module tb_corr_chip_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] f_din = 8'h00;
    logic [7:0] s_din = 8'h00;
    logic f_valid = 1'b0;
    logic s_valid = 1'b0;
    logic f_ready, f_chip, f_busy, f_strobe;
    logic s_ready, s_chip, s_busy, s_strobe;

    int tests = 0;
    int fails = 0;

    bit exp_chip[$];
    bit exp_strb[$];

    always #5 clk = ~clk;

    corr_chip_tx #(.CHIP_DIV(2)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .data_in    (f_din),
        .data_valid (f_valid),
        .data_ready (f_ready),
        .chip_out   (f_chip),
        .busy       (f_busy),
        .bit_strobe (f_strobe)
    );

    corr_chip_tx u_slow (
        .clk        (clk),
        .rst        (rst),
        .data_in    (s_din),
        .data_valid (s_valid),
        .data_ready (s_ready),
        .chip_out   (s_chip),
        .busy       (s_busy),
        .bit_strobe (s_strobe)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: 4 preamble bits MSB first, then data LSB first; each bit
    // is 13 code chips (inverted for a 0), each chip held div clks; then 2 zero chips.
    task automatic build(input logic [7:0] b, input int div);
        bit code[13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};
        bit bits[12];
        exp_chip.delete();
        exp_strb.delete();
        bits[0] = 1; bits[1] = 1; bits[2] = 1; bits[3] = 0;
        for (int i = 0; i < 8; i++) bits[4+i] = b[i];
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 13; c++) begin
                for (int r = 0; r < div; r++) begin
                    exp_chip.push_back(bits[i] ? code[c] : !code[c]);
                    exp_strb.push_back(c == 0 && r == 0);
                end
            end
        end
        for (int r = 0; r < 2 * div; r++) begin
            exp_chip.push_back(1'b0);
            exp_strb.push_back(1'b0);
        end
    endtask

    task automatic send_fast(input logic [7:0] b);
        int n = 0;
        f_din = b;
        f_valid = 1'b1;
        while (f_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", f_ready, 1);
        tick();
        f_valid = 1'b0;
        check("accept_busy", f_busy, 1);
        check("accept_ready", f_ready, 0);
        check("accept_nochip", f_chip, 0);
    endtask

    // Starts just after the transfer edge; stop_at>0 truncates the frame.
    task automatic run_fast(input logic [7:0] b, input int pulse_at,
                            input int stop_at);
        int len, last;
        build(b, 2);
        len = exp_chip.size();
        last = (stop_at > 0) ? stop_at : len;
        for (int k = 1; k <= last; k++) begin
            if (k == pulse_at) begin
                f_din = 8'hFF;
                f_valid = 1'b1;
            end else if (k == pulse_at + 1) begin
                f_valid = 1'b0;
            end
            tick();
            check("chip", f_chip, exp_chip[k-1]);
            check("strobe", f_strobe, exp_strb[k-1]);
            check("busy", f_busy, k < len);
            check("ready", f_ready, k == len);
        end
    endtask

    task automatic idle_fast(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_chip", f_chip, 0);
            check("idle_busy", f_busy, 0);
            check("idle_ready", f_ready, 1);
            check("idle_strobe", f_strobe, 0);
        end
    endtask

    initial begin
        logic [7:0] r;
        int n, busy_cnt, tr_obs, tr_exp, len;
        bit prev_obs, prev_exp;

        // Reset and release
        repeat (3) tick();
        check("rst_ready_f", f_ready, 0);
        check("rst_ready_s", s_ready, 0);
        check("rst_chip", f_chip, 0);
        check("rst_busy", f_busy, 0);
        check("rst_strobe", f_strobe, 0);
        rst = 1'b1;
        check("pre_edge_ready", f_ready, 0);
        tick();
        check("release_ready_f", f_ready, 1);
        check("release_ready_s", s_ready, 1);
        idle_fast(100);

        // Single frame A5
        send_fast(8'hA5);
        run_fast(8'hA5, -1, 0);
        idle_fast(3);

        // Back-to-back with data_valid held: 00 then 01
        f_din = 8'h00;
        f_valid = 1'b1;
        tick();
        f_din = 8'h01;
        check("b2b_busy0", f_busy, 1);
        run_fast(8'h00, -1, 0);
        tick();
        f_valid = 1'b0;
        check("b2b_accept_busy", f_busy, 1);
        check("b2b_accept_ready", f_ready, 0);
        run_fast(8'h01, -1, 0);
        idle_fast(3);

        // data_valid pulsed mid-frame is ignored
        r = 8'($urandom_range(0, 255));
        send_fast(r);
        run_fast(r, 100, 0);
        idle_fast(40);

        // Reset during data bit 3
        r = 8'($urandom_range(0, 255));
        send_fast(r);
        run_fast(r, -1, 190);
        rst = 1'b0;
        tick();
        check("midrst_chip", f_chip, 0);
        check("midrst_busy", f_busy, 0);
        check("midrst_ready", f_ready, 0);
        rst = 1'b1;
        tick();
        check("midrst_release_ready", f_ready, 1);
        idle_fast(40);

        // Random bytes
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            send_fast(r);
            run_fast(r, -1, 0);
            idle_fast(2);
        end

        // Default-parameter instance, byte 3C
        s_din = 8'h3C;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("slow_ready_wait", s_ready, 1);
        tick();
        s_valid = 1'b0;
        build(8'h3C, 16);
        len = exp_chip.size();
        busy_cnt = s_busy ? 1 : 0;
        tr_obs = 0;
        tr_exp = 0;
        prev_obs = 1'b0;
        prev_exp = 1'b0;
        for (int k = 1; k <= len + 10; k++) begin
            tick();
            if (s_busy) busy_cnt++;
            if (k <= len) begin
                check("slow_chip", s_chip, exp_chip[k-1]);
                check("slow_strobe", s_strobe, exp_strb[k-1]);
                if (s_chip != prev_obs) tr_obs++;
                if (exp_chip[k-1] != prev_exp) tr_exp++;
                prev_obs = s_chip;
                prev_exp = exp_chip[k-1];
            end
        end
        check("slow_busy_len", busy_cnt, (4 + 8) * 13 * 16 + 2 * 16);
        check("slow_transitions", tr_obs, tr_exp);
        check("slow_ready_end", s_ready, 1);
        check("slow_chip_end", s_chip, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
